controle_multiciclo: RTL

Multicycle control unit for the RV32I core. Decodes the opcode latched in the instruction register and sequences the shared datapath: one ALU, one memory port, PC/IR/ALUOut registers and the immediate generator. Each state drives the datapath multiplexer selects and write strobes. A ready handshake makes fetch and data-memory states stretch for slow memory.

---
 rtl/controle_multiciclo_pkg.sv | 49 ++++
 rtl/controle_multiciclo.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/controle_multiciclo_pkg.sv
// Opcode, state and datapath-select encodings shared by the RV32I multicycle control unit.
package controle_multiciclo_pkg;

  typedef enum logic [3:0] {
    ST_FETCH    = 4'd0,
    ST_DECODE   = 4'd1,
    ST_EXEC_R   = 4'd2,
    ST_EXEC_I   = 4'd3,
    ST_ENDERECO = 4'd4,
    ST_MEM_LE   = 4'd5,
    ST_MEM_ESC  = 4'd6,
    ST_WB_ALU   = 4'd7,
    ST_WB_MEM   = 4'd8,
    ST_BRANCH   = 4'd9,
    ST_JAL      = 4'd10,
    ST_JALR     = 4'd11,
    ST_LUI      = 4'd12,
    ST_AUIPC    = 4'd13,
    ST_ERRO     = 4'd15
  } estado_t;

  localparam logic [6:0] OPC_REG    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [1:0] ALUA_PC     = 2'd0;
  localparam logic [1:0] ALUA_PCBACK = 2'd1;
  localparam logic [1:0] ALUA_RS1    = 2'd2;
  localparam logic [1:0] ALUA_ZERO   = 2'd3;

  localparam logic [1:0] ALUB_RS2 = 2'd0;
  localparam logic [1:0] ALUB_4   = 2'd1;
  localparam logic [1:0] ALUB_IMM = 2'd2;

  localparam logic [1:0] M2R_ALU = 2'd0;
  localparam logic [1:0] M2R_MEM = 2'd1;
  localparam logic [1:0] M2R_PC  = 2'd2;

  localparam logic [1:0] ALUOP_ADD    = 2'd0;
  localparam logic [1:0] ALUOP_BRANCH = 2'd1;
  localparam logic [1:0] ALUOP_FUNCT  = 2'd2;

endpackage

// File: rtl/controle_multiciclo.sv
// Multicycle RV32I control FSM: state register plus combinational next-state/output decode.
module controle_multiciclo
  import controle_multiciclo_pkg::*;
(
  input  logic       iCLK,
  input  logic       iRST,
  input  logic [6:0] iOpcode,
  input  logic       iMemPronta,
  output logic       oEscreveIR,
  output logic       oEscrevePC,
  output logic       oEscrevePCBack,
  output logic       oEscrevePCCond,
  output logic       oLeMem,
  output logic       oEscreveMem,
  output logic       oIouD,
  output logic       oEscreveReg,
  output logic [1:0] oMem2Reg,
  output logic [1:0] oOrigAULA,
  output logic [1:0] oOrigBULA,
  output logic [1:0] oALUOp,
  output logic       oOrigPC,
  output logic [3:0] oEstado,
  output logic       oInvalida
);

  estado_t estado, proximo;
  logic    eh_load, eh_load_prox;
  logic    pronta;

  // Outputs are decoded from state, so the fetch strobes are also gated by reset
  // to keep them quiet while iRST is low.
  assign pronta  = iMemPronta & iRST;
  assign oEstado = estado;

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      estado  <= ST_FETCH;
      eh_load <= 1'b0;
    end else begin
      estado  <= proximo;
      eh_load <= eh_load_prox;
    end
  end

  always_comb begin
    proximo        = estado;
    eh_load_prox   = eh_load;
    oEscreveIR     = 1'b0;
    oEscrevePC     = 1'b0;
    oEscrevePCBack = 1'b0;
    oEscrevePCCond = 1'b0;
    oLeMem         = 1'b0;
    oEscreveMem    = 1'b0;
    oIouD          = 1'b0;
    oEscreveReg    = 1'b0;
    oMem2Reg       = M2R_ALU;
    oOrigAULA      = ALUA_PC;
    oOrigBULA      = ALUB_RS2;
    oALUOp         = ALUOP_ADD;
    oOrigPC        = 1'b0;
    oInvalida      = 1'b0;
    unique case (estado)
      ST_FETCH: begin
        oLeMem    = 1'b1;
        oOrigBULA = ALUB_4;
        if (pronta) begin
          oEscreveIR     = 1'b1;
          oEscrevePC     = 1'b1;
          oEscrevePCBack = 1'b1;
          proximo        = ST_DECODE;
        end
      end
      ST_DECODE: begin
        oOrigAULA    = ALUA_PCBACK;
        oOrigBULA    = ALUB_IMM;
        // Latch load/store here so ENDERECO does not depend on the opcode input.
        eh_load_prox = (iOpcode == OPC_LOAD);
        case (iOpcode)
          OPC_REG:             proximo = ST_EXEC_R;
          OPC_OPIMM:           proximo = ST_EXEC_I;
          OPC_LOAD, OPC_STORE: proximo = ST_ENDERECO;
          OPC_BRANCH:          proximo = ST_BRANCH;
          OPC_JAL:             proximo = ST_JAL;
          OPC_JALR:            proximo = ST_JALR;
          OPC_LUI:             proximo = ST_LUI;
          OPC_AUIPC:           proximo = ST_AUIPC;
          default:             proximo = ST_ERRO;
        endcase
      end
      ST_EXEC_R: begin
        oOrigAULA = ALUA_RS1;
        oOrigBULA = ALUB_RS2;
        oALUOp    = ALUOP_FUNCT;
        proximo   = ST_WB_ALU;
      end
      ST_EXEC_I: begin
        oOrigAULA = ALUA_RS1;
        oOrigBULA = ALUB_IMM;
        oALUOp    = ALUOP_FUNCT;
        proximo   = ST_WB_ALU;
      end
      ST_LUI: begin
        oOrigAULA = ALUA_ZERO;
        oOrigBULA = ALUB_IMM;
        proximo   = ST_WB_ALU;
      end
      ST_AUIPC: begin
        oOrigAULA = ALUA_PCBACK;
        oOrigBULA = ALUB_IMM;
        proximo   = ST_WB_ALU;
      end
      ST_ENDERECO: begin
        oOrigAULA = ALUA_RS1;
        oOrigBULA = ALUB_IMM;
        proximo   = eh_load ? ST_MEM_LE : ST_MEM_ESC;
      end
      ST_MEM_LE: begin
        oLeMem = 1'b1;
        oIouD  = 1'b1;
        if (pronta) proximo = ST_WB_MEM;
      end
      ST_MEM_ESC: begin
        oEscreveMem = 1'b1;
        oIouD       = 1'b1;
        if (pronta) proximo = ST_FETCH;
      end
      ST_WB_ALU: begin
        oEscreveReg = 1'b1;
        oMem2Reg    = M2R_ALU;
        proximo     = ST_FETCH;
      end
      ST_WB_MEM: begin
        oEscreveReg = 1'b1;
        oMem2Reg    = M2R_MEM;
        proximo     = ST_FETCH;
      end
      ST_BRANCH: begin
        oOrigAULA      = ALUA_RS1;
        oOrigBULA      = ALUB_RS2;
        oALUOp         = ALUOP_BRANCH;
        oEscrevePCCond = 1'b1;
        oOrigPC        = 1'b1;
        proximo        = ST_FETCH;
      end
      ST_JAL: begin
        oEscreveReg = 1'b1;
        oMem2Reg    = M2R_PC;
        oEscrevePC  = 1'b1;
        oOrigPC     = 1'b1;
        proximo     = ST_FETCH;
      end
      ST_JALR: begin
        oOrigAULA   = ALUA_RS1;
        oOrigBULA   = ALUB_IMM;
        oEscreveReg = 1'b1;
        oMem2Reg    = M2R_PC;
        oEscrevePC  = 1'b1;
        oOrigPC     = 1'b0;
        proximo     = ST_FETCH;
      end
      ST_ERRO: begin
        oInvalida = 1'b1;
        proximo   = ST_ERRO;
      end
      default: proximo = ST_ERRO;
    endcase
  end

endmodule
